hand_manager: RTL and testbench

- Per-player hand buffer that sits directly downstream of the deck block.
- Issues draw requests to the deck, captures each drawn card, and stores up to MAX_CARDS cards in insertion order.
- Checks a selected card for legality against the active discard state, emits the card on a legal play, and compacts the hand over multiple cycles.
- One instance per player. The top-level arbiter enables one player at a time.

---
 rtl/uno_pkg.sv | 29 ++
 rtl/card_match.sv | 24 ++
 rtl/hand_manager.sv | 200 ++++++++++++++++++++
 tb/tb_hand_manager.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uno_pkg.sv
// Shared card types and constants for the UNO card-handling blocks.
package uno_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2,
    BLUE   = 2'd3
  } color_e;

  typedef struct packed {
    logic [1:0] color;
    logic [3:0] value;
  } card_t;

  localparam logic [3:0] V_SKIP    = 4'd10;
  localparam logic [3:0] V_REV     = 4'd11;
  localparam logic [3:0] V_DRAW2   = 4'd12;
  localparam logic [3:0] V_WILD    = 4'd13;
  localparam logic [3:0] V_WD4     = 4'd14;
  localparam logic [3:0] V_INVALID = 4'd15;

  localparam card_t EMPTY_CARD = 6'h3F;

  function automatic logic is_wild(input card_t c);
    return (c.value == V_WILD) || (c.value == V_WD4);
  endfunction

endpackage

// File: rtl/card_match.sv
// Combinational legality check of one card against the discard top and active colour.
module card_match
  import uno_pkg::*;
(
  input  card_t      i_card,
  input  card_t      i_top,
  input  logic [1:0] i_cur_color,
  output logic       o_legal
);

  always_comb begin
    o_legal = 1'b0;
    if (i_card.value == V_INVALID) begin
      o_legal = 1'b0;
    end else if (is_wild(i_card)) begin
      o_legal = 1'b1;
    end else if (i_card.color == i_cur_color) begin
      o_legal = 1'b1;
    end else if ((i_card.value == i_top.value) && (i_card.value <= V_DRAW2)) begin
      o_legal = 1'b1;
    end
  end

endmodule

// File: rtl/hand_manager.sv
// Per-player hand buffer: draws from the deck, checks/plays a selected card, compacts the hand.
// Optional HAND_STRICT_WD4_EN: wild-draw-4 legal only if no other held card matches the active colour.
module hand_manager
  import uno_pkg::*;
#(
  parameter int MAX_CARDS = 20,
  parameter int IDX_W     = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic [2:0]       i_draw_req,
  output logic [2:0]       o_draw,
  input  logic             i_drawn,
  input  logic [5:0]       i_card,
  input  logic             i_play,
  input  logic [IDX_W-1:0] i_sel,
  input  logic [5:0]       i_top,
  input  logic [1:0]       i_cur_color,
  output logic             o_play_ok,
  output logic             o_play_err,
  output logic [5:0]       o_played_card,
  output logic             o_draw_done,
  output logic             o_overflow,
  output logic [IDX_W-1:0] o_count,
  output logic             o_busy,
  input  logic [IDX_W-1:0] i_view_idx,
  output logic [5:0]       o_view_card
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAW,
    S_SHIFT
  } state_e;

  localparam logic [IDX_W-1:0] CAP = IDX_W'(MAX_CARDS);

  state_e           r_state;
  card_t            r_hand [MAX_CARDS];
  logic [IDX_W-1:0] r_count;
  logic [IDX_W-1:0] r_remain;
  logic [IDX_W-1:0] r_ptr;
  logic [2:0]       r_draw;
  logic             r_play_ok;
  logic             r_play_err;
  card_t            r_played_card;
  logic             r_draw_done;
  logic             r_overflow;
  logic             r_busy;

  card_t            w_sel_card;
  logic             w_base_legal;
  logic             w_legal;
  logic             w_sel_ok;
  logic [IDX_W-1:0] w_req_n;
  logic [IDX_W-1:0] w_room;
  logic [IDX_W-1:0] w_take;
  logic [IDX_W-1:0] w_last_idx;
  logic [IDX_W-1:0] w_ptr_inc;

  assign w_sel_card = (i_sel < CAP) ? r_hand[i_sel] : EMPTY_CARD;

  card_match u_card_match (
    .i_card      (w_sel_card),
    .i_top       (i_top),
    .i_cur_color (i_cur_color),
    .o_legal     (w_base_legal)
  );

`ifdef HAND_STRICT_WD4_EN
  logic [MAX_CARDS-1:0] w_color_hit;

  // Any other held card in the active colour blocks a wild-draw-4.
  for (genvar gi = 0; gi < MAX_CARDS; gi++) begin : g_color_hit
    assign w_color_hit[gi] = (IDX_W'(gi) < r_count) && (IDX_W'(gi) != i_sel) &&
                             (r_hand[gi].color == i_cur_color);
  end

  assign w_legal = w_base_legal && !((w_sel_card.value == V_WD4) && (|w_color_hit));
`else
  assign w_legal = w_base_legal;
`endif

  assign w_sel_ok   = (i_sel < r_count) && w_legal;
  assign w_room     = CAP - r_count;
  assign w_take     = (w_req_n > w_room) ? w_room : w_req_n;
  assign w_last_idx = r_count - 1'b1;
  assign w_ptr_inc  = r_ptr + 1'b1;

  always_comb begin
    w_req_n = '0;
    case (i_draw_req)
      3'b001:  w_req_n = IDX_W'(1);
      3'b010:  w_req_n = IDX_W'(2);
      3'b100:  w_req_n = IDX_W'(4);
      default: w_req_n = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_remain      <= '0;
      r_ptr         <= '0;
      r_draw        <= '0;
      r_play_ok     <= 1'b0;
      r_play_err    <= 1'b0;
      r_played_card <= '0;
      r_draw_done   <= 1'b0;
      r_overflow    <= 1'b0;
      r_busy        <= 1'b0;
      for (int i = 0; i < MAX_CARDS; i++) r_hand[i] <= EMPTY_CARD;
    end else begin
      r_play_ok   <= 1'b0;
      r_play_err  <= 1'b0;
      r_draw_done <= 1'b0;
      if (i_clear) begin
        r_state    <= S_IDLE;
        r_busy     <= 1'b0;
        r_count    <= '0;
        r_remain   <= '0;
        r_draw     <= '0;
        r_overflow <= 1'b0;
        for (int i = 0; i < MAX_CARDS; i++) r_hand[i] <= EMPTY_CARD;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_play) begin
              if (w_sel_ok) begin
                r_played_card <= w_sel_card;
                r_play_ok     <= 1'b1;
                // Removing the last card needs no compaction.
                if (i_sel == w_last_idx) begin
                  r_hand[i_sel] <= EMPTY_CARD;
                  r_count       <= w_last_idx;
                end else begin
                  r_ptr   <= i_sel;
                  r_state <= S_SHIFT;
                  r_busy  <= 1'b1;
                end
              end else begin
                r_play_err <= 1'b1;
              end
            end else if (w_req_n != '0) begin
              if (w_req_n > w_room) r_overflow <= 1'b1;
              if (w_take == '0) begin
                r_draw_done <= 1'b1;
              end else begin
                r_remain <= w_take;
                r_draw   <= i_draw_req;
                r_state  <= S_DRAW;
                r_busy   <= 1'b1;
              end
            end
          end
          S_DRAW: begin
            if (i_drawn) begin
              r_hand[r_count] <= i_card;
              r_count         <= r_count + 1'b1;
              r_remain        <= r_remain - 1'b1;
              if (r_remain == IDX_W'(1)) begin
                r_draw      <= '0;
                r_draw_done <= 1'b1;
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
              end
            end
          end
          S_SHIFT: begin
            r_hand[r_ptr] <= r_hand[w_ptr_inc];
            r_ptr         <= w_ptr_inc;
            if (w_ptr_inc == w_last_idx) begin
              r_hand[w_last_idx] <= EMPTY_CARD;
              r_count            <= w_last_idx;
              r_state            <= S_IDLE;
              r_busy             <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_draw        = r_draw;
  assign o_play_ok     = r_play_ok;
  assign o_play_err    = r_play_err;
  assign o_played_card = r_played_card;
  assign o_draw_done   = r_draw_done;
  assign o_overflow    = r_overflow;
  assign o_count       = r_count;
  assign o_busy        = r_busy;
  assign o_view_card   = (i_view_idx < r_count) ? r_hand[i_view_idx] : EMPTY_CARD;

endmodule

// File: tb/tb_hand_manager.sv
// Testbench for hand_manager: directed steps then random ops against a queue-based hand model.
module tb_hand_manager;

  localparam int MAXC = 20;
  localparam int IW   = 5;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_clear;
  logic [2:0]    i_draw_req;
  logic [2:0]    o_draw;
  logic          i_drawn;
  logic [5:0]    i_card;
  logic          i_play;
  logic [IW-1:0] i_sel;
  logic [5:0]    i_top;
  logic [1:0]    i_cur_color;
  logic          o_play_ok;
  logic          o_play_err;
  logic [5:0]    o_played_card;
  logic          o_draw_done;
  logic          o_overflow;
  logic [IW-1:0] o_count;
  logic          o_busy;
  logic [IW-1:0] i_view_idx;
  logic [5:0]    o_view_card;

  always #5 i_clk = ~i_clk;

  hand_manager #(.MAX_CARDS(MAXC), .IDX_W(IW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear), .i_draw_req(i_draw_req),
    .o_draw(o_draw), .i_drawn(i_drawn), .i_card(i_card), .i_play(i_play), .i_sel(i_sel),
    .i_top(i_top), .i_cur_color(i_cur_color), .o_play_ok(o_play_ok), .o_play_err(o_play_err),
    .o_played_card(o_played_card), .o_draw_done(o_draw_done), .o_overflow(o_overflow),
    .o_count(o_count), .o_busy(o_busy), .i_view_idx(i_view_idx), .o_view_card(o_view_card)
  );

  logic [5:0] hq[$];
  logic [5:0] deck_q[$];
  bit         ov_m;
  int         tests = 0;
  int         fails = 0;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal_m(input logic [5:0] c, input logic [5:0] top,
                                 input logic [1:0] cc, input int sel);
    logic [3:0] v;
    v = c[3:0];
    if (v == 4'd15) return 1'b0;
    if (v == 4'd14) begin
`ifdef HAND_STRICT_WD4_EN
      foreach (hq[j]) if (j != sel && hq[j][5:4] == cc) return 1'b0;
`endif
      return 1'b1;
    end
    if (v == 4'd13) return 1'b1;
    if (c[5:4] == cc) return 1'b1;
    if (v == top[3:0] && v <= 4'd12) return 1'b1;
    return 1'b0;
  endfunction

  task automatic view_all();
    for (int i = 0; i <= hq.size(); i++) begin
      i_view_idx = i[IW-1:0];
      #2;
      chk("view", o_view_card, (i < hq.size()) ? hq[i] : 6'h3F);
      tick();
    end
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    hq.delete();
    ov_m = 1'b0;
    chk("clr_count", o_count, 0);
    chk("clr_draw", o_draw, 0);
    chk("clr_busy", o_busy, 0);
    chk("clr_ovf", o_overflow, 0);
    chk("clr_pulse", {o_play_ok, o_play_err, o_draw_done}, 0);
    $display("[TB] clear");
  endtask

  task automatic draw_seq(input logic [2:0] req);
    int n, room, rem;
    logic [5:0] c;
    n    = (req == 3'b001) ? 1 : (req == 3'b010) ? 2 : (req == 3'b100) ? 4 : 0;
    room = MAXC - hq.size();
    rem  = (n < room) ? n : room;
    i_draw_req = req;
    tick();
    i_draw_req = 3'b000;
    if (n > room) ov_m = 1'b1;
    if (n == 0) begin
      chk("nohot_busy", o_busy, 0);
      chk("nohot_done", o_draw_done, 0);
      chk("nohot_draw", o_draw, 0);
    end else if (rem == 0) begin
      chk("full_done", o_draw_done, 1);
      chk("full_draw", o_draw, 0);
      chk("full_busy", o_busy, 0);
    end else begin
      for (int k = 0; k < rem; k++) begin
        if ($urandom_range(0, 3) == 0) tick();
        chk("draw_hold", o_draw, req);
        chk("draw_busy", o_busy, 1);
        chk("draw_early", o_draw_done, 0);
        c = (deck_q.size() > 0) ? deck_q.pop_front() : 6'($urandom);
        i_drawn = 1'b1;
        i_card  = c;
        tick();
        i_drawn = 1'b0;
        hq.push_back(c);
      end
      chk("draw_done", o_draw_done, 1);
      chk("draw_off", o_draw, 0);
      chk("draw_idle", o_busy, 0);
    end
    chk("draw_count", o_count, hq.size());
    chk("draw_ovf", o_overflow, ov_m);
    $display("[TB] draw req=%b n=%0d taken=%0d count=%0d ovf=%0d", req, n, rem, hq.size(), ov_m);
    // A stray strobe while idle must not add a card.
    i_drawn = 1'b1;
    i_card  = 6'($urandom);
    tick();
    i_drawn = 1'b0;
    chk("done_pulse", o_draw_done, 0);
    chk("stray_strobe", o_count, hq.size());
  endtask

  task automatic play(input int sel, input logic [5:0] top, input logic [1:0] cc);
    bit lg;
    int shift;
    logic [5:0] pc;
    lg = 1'b0;
    if (sel < hq.size()) lg = legal_m(hq[sel], top, cc, sel);
    i_play      = 1'b1;
    i_sel       = sel[IW-1:0];
    i_top       = top;
    i_cur_color = cc;
    tick();
    i_play = 1'b0;
    if (lg) begin
      pc    = hq[sel];
      shift = hq.size() - 1 - sel;
      hq.delete(sel);
      chk("play_ok", o_play_ok, 1);
      chk("play_noerr", o_play_err, 0);
      chk("played_card", o_played_card, pc);
      for (int s = 0; s < shift; s++) begin
        chk("shift_busy", o_busy, 1);
        if (s == 0) begin
          i_play     = 1'b1;
          i_sel      = 5'd31;
          i_draw_req = 3'b001;
        end
        tick();
        i_play     = 1'b0;
        i_draw_req = 3'b000;
        chk("busy_ignore", {o_play_ok, o_play_err, o_draw_done}, 0);
      end
      chk("shift_idle", o_busy, 0);
      chk("play_count", o_count, hq.size());
    end else begin
      chk("play_err", o_play_err, 1);
      chk("play_nook", o_play_ok, 0);
      chk("err_count", o_count, hq.size());
      chk("err_busy", o_busy, 0);
    end
    $display("[TB] play sel=%0d top=%02h col=%0d legal=%0d count=%0d", sel, top, cc, lg, hq.size());
    tick();
    chk("play_pulse", {o_play_ok, o_play_err}, 0);
    view_all();
  endtask

  initial begin
    int r;
    i_rst_n = 1'b0; i_clear = 1'b0; i_draw_req = '0; i_drawn = 1'b0; i_card = '0;
    i_play = 1'b0; i_sel = '0; i_top = '0; i_cur_color = '0; i_view_idx = '0;
    ov_m = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    tick();
    chk("rst_count", o_count, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_draw", o_draw, 0);
    chk("rst_pulses", {o_play_ok, o_play_err, o_draw_done, o_overflow}, 0);
    chk("rst_played", o_played_card, 0);
    chk("rst_view", o_view_card, 6'h3F);

    // Draw four known cards and check the display port directly.
    deck_q = '{6'h05, 6'h11, 6'h2C, 6'h3D};
    draw_seq(3'b100);
    i_view_idx = 5'd2;
    #2;
    chk("t1_view2", o_view_card, 6'h2C);
    tick();
    play(0, 6'h25, 2'd2);

    do_clear();
    deck_q = '{6'h05, 6'h11, 6'h2C, 6'h3D};
    draw_seq(3'b100);
    play(1, 6'h27, 2'd0);
    play(3, 6'h27, 2'd0);

    // Capacity boundary: fill to 19, then a truncated draw and a full-hand draw.
    do_clear();
    repeat (4) draw_seq(3'b100);
    draw_seq(3'b010);
    draw_seq(3'b001);
    draw_seq(3'b010);
    chk("cap_ovf", o_overflow, 1);
    chk("cap_count", o_count, 20);
    draw_seq(3'b001);

    // Clear in the middle of a draw sequence.
    i_draw_req = 3'b100;
    do_clear();
    i_draw_req = 3'b100;
    tick();
    i_draw_req = 3'b000;
    i_drawn = 1'b1;
    i_card  = 6'h12;
    tick();
    i_drawn = 1'b0;
    do_clear();
    view_all();

    // Wild-draw-4 with another card in the active colour.
    deck_q = '{6'h0E, 6'h03};
    draw_seq(3'b010);
    play(0, 6'h15, 2'd0);

    // Asynchronous reset drops the draw command without waiting for a clock.
    do_clear();
    i_draw_req = 3'b100;
    tick();
    i_draw_req = 3'b000;
    chk("ar_draw_on", o_draw, 3'b100);
    #1 i_rst_n = 1'b0;
    #1;
    chk("ar_draw_off", o_draw, 0);
    chk("ar_busy", o_busy, 0);
    chk("ar_count", o_count, 0);
    tick();
    i_rst_n = 1'b1;
    hq.delete();
    ov_m = 1'b0;
    tick();

    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        do_clear();
      end else if (r == 1) begin
        draw_seq(($urandom_range(0, 1) == 0) ? 3'b000 : 3'b011);
      end else if (r <= 4) begin
        case ($urandom_range(0, 2))
          0:       draw_seq(3'b001);
          1:       draw_seq(3'b010);
          default: draw_seq(3'b100);
        endcase
      end else begin
        play($urandom_range(0, hq.size() + 1), 6'($urandom), 2'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
